// File: rtl/ov7670_pkg.sv
// Shared constants and the RGB565 pixel type for the OV7670 capture path.
package ov7670_pkg;

  localparam int OV_H_ACTIVE = 640;
  localparam int OV_V_ACTIVE = 480;
  localparam int OV_COL_W    = 10;
  localparam int OV_ROW_W    = 9;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic rgb565_t pack_rgb565(input logic [7:0] high_byte, input logic [7:0] low_byte);
    return rgb565_t'({high_byte, low_byte});
  endfunction

endpackage

// File: rtl/ov7670_byte_packer.sv
// Pairs camera bytes into RGB565 pixels: phase flop, high-byte register and
// a combinational pixel-complete strobe on the edge that samples the low byte.
module ov7670_byte_packer
  import ov7670_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_en,
  input  logic [7:0] data,
  output rgb565_t    pixel,
  output logic       pixel_done
);

  logic       phase;
  logic [7:0] high_byte;

  // Phase toggles per accepted byte and drops back to 0 whenever bytes stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      high_byte <= 8'h00;
    end else if (byte_en) begin
      phase <= ~phase;
      if (!phase) begin
        high_byte <= data;
      end else begin
        high_byte <= high_byte;
      end
    end else begin
      phase     <= 1'b0;
      high_byte <= high_byte;
    end
  end

  // Pixel is complete when the second byte of the pair is on the bus.
  always_comb begin
    pixel      = pack_rgb565(high_byte, data);
    pixel_done = byte_en & phase;
  end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 RGB565 capture: packs bytes into pixels and tags them with row/column.
// Optional frame_done pulse is built when CAPTURE_FRAME_DONE_EN is defined.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = OV_H_ACTIVE,
  parameter int V_ACTIVE = OV_V_ACTIVE
) (
  input  logic                clock_pclk,
  input  logic                pin_reset,
  input  logic                vs,
  input  logic                href,
  input  logic [7:0]          data,
  output logic [15:0]         o_data,
  output logic                flag,
  output logic [OV_ROW_W-1:0] o_row,
  output logic [OV_COL_W-1:0] o_col
`ifdef CAPTURE_FRAME_DONE_EN
  ,
  output logic                frame_done
`endif
);

  localparam logic [OV_COL_W-1:0] H_MAX    = OV_COL_W'(H_ACTIVE);
  localparam logic [OV_ROW_W-1:0] V_MAX    = OV_ROW_W'(V_ACTIVE);
  localparam logic [OV_COL_W-1:0] LAST_COL = OV_COL_W'(H_ACTIVE - 1);
  localparam logic [OV_ROW_W-1:0] LAST_ROW = OV_ROW_W'(V_ACTIVE - 1);

  logic                href_d;
  logic                armed;
  logic                line_had;
  logic [OV_COL_W-1:0] x;
  logic [OV_ROW_W-1:0] y;
  logic                byte_en;
  logic                href_fall;
  logic                emit;
  rgb565_t             pixel;
  logic                pixel_done;

  // After reset, bytes are ignored until vs is seen or href rises, so a
  // partially captured line never starts a frame.
  always_comb begin
    byte_en   = href & ~vs & (armed | ~href_d);
    href_fall = href_d & ~href & ~vs;
    emit      = pixel_done & (x < H_MAX) & (y < V_MAX);
  end

  ov7670_byte_packer u_packer (
    .clk        (clock_pclk),
    .rst        (pin_reset),
    .byte_en    (byte_en),
    .data       (data),
    .pixel      (pixel),
    .pixel_done (pixel_done)
  );

  // Row/column counters and registered pixel outputs; vs overrides href.
  always_ff @(posedge clock_pclk or posedge pin_reset) begin
    if (pin_reset) begin
      href_d   <= 1'b1;
      armed    <= 1'b0;
      line_had <= 1'b0;
      x        <= '0;
      y        <= '0;
      o_data   <= 16'h0000;
      o_row    <= '0;
      o_col    <= '0;
      flag     <= 1'b0;
    end else begin
      href_d <= href;
      flag   <= 1'b0;
      if (vs) begin
        armed    <= 1'b1;
        line_had <= 1'b0;
        x        <= '0;
        y        <= '0;
      end else begin
        if (href && !href_d) begin
          armed <= 1'b1;
        end
        if (href_fall) begin
          x        <= '0;
          line_had <= 1'b0;
          if (line_had && (y < V_MAX)) begin
            y <= y + OV_ROW_W'(1);
          end
        end else if (emit) begin
          o_data   <= pixel;
          o_col    <= x;
          o_row    <= y;
          flag     <= 1'b1;
          x        <= x + OV_COL_W'(1);
          line_had <= 1'b1;
        end
      end
    end
  end

`ifdef CAPTURE_FRAME_DONE_EN
  logic fd_armed;
  logic corner_hit;

  always_comb begin
    corner_hit = flag & (o_row == LAST_ROW) & (o_col == LAST_COL) & fd_armed;
  end

  // One pulse the edge after the bottom-right pixel; vs re-arms it.
  always_ff @(posedge clock_pclk or posedge pin_reset) begin
    if (pin_reset) begin
      frame_done <= 1'b0;
      fd_armed   <= 1'b1;
    end else begin
      frame_done <= corner_hit;
      if (vs) begin
        fd_armed <= 1'b1;
      end else if (corner_hit) begin
        fd_armed <= 1'b0;
      end else begin
        fd_armed <= fd_armed;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Randomised bench for ov7670_pixel_capture with a line-level reference model.
module tb_ov7670_pixel_capture;
  import ov7670_pkg::*;

  logic        clock_pclk = 1'b0;
  logic        pin_reset;
  logic        vs;
  logic        href;
  logic [7:0]  data;
  logic [15:0] o_data;
  logic        flag;
  logic [8:0]  o_row;
  logic [9:0]  o_col;
`ifdef CAPTURE_FRAME_DONE_EN
  logic        frame_done;
`endif

  ov7670_pixel_capture dut (
    .clock_pclk (clock_pclk),
    .pin_reset  (pin_reset),
    .vs         (vs),
    .href       (href),
    .data       (data),
    .o_data     (o_data),
    .flag       (flag),
    .o_row      (o_row),
    .o_col      (o_col)
`ifdef CAPTURE_FRAME_DONE_EN
    ,
    .frame_done (frame_done)
`endif
  );

  always #5 clock_pclk = ~clock_pclk;

  typedef struct {
    logic [15:0] d;
    int          row;
    int          col;
    int          cyc;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  exp_t        q[$];
  logic [7:0]  line[$];
  int          mrow;
  bit          marmed;
  bit          line_emit;
  logic [15:0] last_d;
  int          last_r;
  int          last_c;
  int          fd_exp = 0;
  int          fd_seen = 0;
  int          corner_cyc = -10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clock_pclk) cyc <= cyc + 1;

  // Monitor: every flag must match the next expected pixel; otherwise outputs hold.
  always @(posedge clock_pclk) begin
    exp_t e;
    #1;
    if (!pin_reset) begin
      if (flag) begin
        if (q.size() == 0) begin
          check("extra_flag", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("data", o_data, e.d);
          check("row", o_row, e.row);
          check("col", o_col, e.col);
          check("latency", cyc, e.cyc);
          last_d = e.d;
          last_r = e.row;
          last_c = e.col;
          if (e.row == 479 && e.col == 639) corner_cyc = cyc;
        end
      end else begin
        check("hold_data", o_data, last_d);
        check("hold_row", o_row, last_r);
        check("hold_col", o_col, last_c);
      end
`ifdef CAPTURE_FRAME_DONE_EN
      if (frame_done) begin
        fd_seen++;
        check("fd_time", cyc, corner_cyc + 1);
      end
`endif
    end
  end

  task automatic put_byte(input logic [7:0] b);
    int k;
    exp_t e;
    @(negedge clock_pclk);
    vs   = 1'b0;
    href = 1'b1;
    data = b;
    line.push_back(b);
    if (line.size() % 2 == 0) begin
      k = line.size() / 2 - 1;
      if (marmed && k < 640 && mrow < 480) begin
        e.d   = {line[2*k], line[2*k+1]};
        e.row = mrow;
        e.col = k;
        e.cyc = cyc + 1;
        q.push_back(e);
        line_emit = 1'b1;
        if (mrow == 479 && k == 639) fd_exp++;
      end
    end
  endtask

  task automatic put_rand(input int n);
    for (int i = 0; i < n; i++) put_byte(8'($urandom));
  endtask

  task automatic end_line(input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clock_pclk);
      href = 1'b0;
      data = 8'($urandom);
    end
    if (line_emit && mrow < 480) mrow++;
    line_emit = 1'b0;
    line.delete();
    marmed = 1'b1;
  endtask

  task automatic vs_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_pclk);
      vs   = 1'b1;
      href = 1'b0;
      data = 8'($urandom);
    end
    mrow      = 0;
    line_emit = 1'b0;
    line.delete();
    marmed    = 1'b1;
  endtask

  task automatic model_reset();
    q.delete();
    line.delete();
    mrow       = 0;
    marmed     = 1'b0;
    line_emit  = 1'b0;
    last_d     = 16'h0000;
    last_r     = 0;
    last_c     = 0;
    corner_cyc = -10;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, o_data, 32'd0);
    check({tag, "_row"}, o_row, 32'd0);
    check({tag, "_col"}, o_col, 32'd0);
    check({tag, "_flag"}, flag, 32'd0);
`ifdef CAPTURE_FRAME_DONE_EN
    check({tag, "_fd"}, frame_done, 32'd0);
`endif
  endtask

  initial begin
    pin_reset = 1'b1;
    vs        = 1'b1;
    href      = 1'b0;
    data      = 8'h00;
    model_reset();
    repeat (3) @(negedge clock_pclk);
    check_zero("rst");
    @(negedge clock_pclk);
    pin_reset = 1'b0;
    vs_pulse(2);

    // single pixel
    put_byte(8'hF8);
    put_byte(8'h1F);
    end_line(3);
    check("single_data", o_data, 32'hF81F);

    // full line then overflowing line
    put_rand(1280);
    end_line(4);
    check("full_last_col", o_col, 32'd639);
    put_rand(1290);
    end_line(4);
    check("ovf_last_col", o_col, 32'd639);

    // odd byte count
    vs_pulse(2);
    put_byte(8'hAA);
    put_byte(8'hBB);
    put_byte(8'hCC);
    end_line(2);
    put_byte(8'h12);
    put_byte(8'h34);
    end_line(2);
    check("odd_data", o_data, 32'h1234);
    check("odd_row", o_row, 32'd1);
    check("odd_col", o_col, 32'd0);

    // random lines with occasional frame restarts
    for (int i = 0; i < 30; i++) begin
      put_rand($urandom_range(0, 40));
      end_line($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) vs_pulse($urandom_range(1, 3));
    end

    // asynchronous reset in the middle of a line
    vs_pulse(2);
    put_rand(7);
    @(posedge clock_pclk);
    #3;
    pin_reset = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    repeat (2) @(negedge clock_pclk);
    pin_reset = 1'b0;
    put_rand(6);
    end_line(3);
    put_byte(8'hF0);
    put_byte(8'h0F);
    end_line(2);
    check("post_rst_data", o_data, 32'hF00F);
    check("post_rst_row", o_row, 32'd0);

    // full frame: 479 short lines, then one full line, then a dropped line
    vs_pulse(2);
    for (int i = 0; i < 479; i++) begin
      put_rand(2);
      end_line(1);
    end
    put_rand(1280);
    end_line(3);
    check("frame_last_row", o_row, 32'd479);
    check("frame_last_col", o_col, 32'd639);
    put_rand(4);
    end_line(2);
    vs_pulse(2);
    put_rand(2);
    end_line(2);
    check("new_frame_row", o_row, 32'd0);
    check("new_frame_col", o_col, 32'd0);

    repeat (3) @(negedge clock_pclk);
    check("missing_pixels", q.size(), 32'd0);
`ifdef CAPTURE_FRAME_DONE_EN
    check("fd_count", fd_seen, fd_exp);
    check("fd_once", fd_exp, 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
